// File: rtl/tff_counter_bank.sv
// Bank of WIDTH toggle flip-flops: per-bit T register, modulo up/down counter or parallel load.
// Registered wrap pulse plus a combinational terminal-count flag for cascading banks.
module tff_counter_bank #(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MOD       = 64'd1 << WIDTH,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             wrap
);

    typedef enum logic [1:0] {
        ModeToggle = 2'b00,
        ModeUp     = 2'b01,
        ModeDown   = 2'b10,
        ModeLoad   = 2'b11
    } mode_e;

    // One extra bit so MOD = 2**WIDTH does not overflow the terminal value.
    localparam logic [WIDTH:0]   MaxCnt = (WIDTH + 1)'(MOD - 64'd1);
    localparam logic [WIDTH-1:0] RstVal = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   q_ext;
    logic             at_top, at_zero, over_top;

    assign q_ext    = {1'b0, q_q};
    assign at_top   = (q_ext >= MaxCnt);
    assign over_top = (q_ext > MaxCnt);
    assign at_zero  = (q_q == '0);

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (en) begin
            unique case (mode)
                ModeToggle: q_d = q_q ^ t;
                ModeUp: begin
                    if (at_top) begin
                        q_d    = '0;
                        wrap_d = 1'b1;
                    end else begin
                        q_d = q_q + 1'b1;
                    end
                end
                ModeDown: begin
                    if (at_zero) begin
                        q_d    = MaxCnt[WIDTH-1:0];
                        wrap_d = 1'b1;
                    end else if (over_top) begin
                        // Out-of-range value is clamped into range without a wrap.
                        q_d = MaxCnt[WIDTH-1:0];
                    end else begin
                        q_d = q_q - 1'b1;
                    end
                end
                ModeLoad: q_d = d;
                default:  q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= RstVal;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign qb   = ~q_q;
    assign wrap = wrap_q;
    assign tc   = en & (((mode == ModeUp) & at_top) | ((mode == ModeDown) & at_zero));

endmodule

// File: tb/tb_tff_counter_bank.sv
// Self-checking bench for tff_counter_bank (WIDTH=4, MOD=10): integer model plus directed vectors,
// with a second bank cascaded on the first bank's terminal count.
module tb_tff_counter_bank;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic         clk, rst, en;
    logic [1:0]   mode;
    logic [W-1:0] t, d;
    logic [W-1:0] q_a, qb_a, q_b, qb_b;
    logic         tc_a, wrap_a, tc_b, wrap_b;
    logic [W-1:0] zero_w;

    int  n_pass  = 0;
    int  n_total = 0;
    bit  chk_on  = 0;
    int  ma      = 0;
    int  mb      = 0;
    bit  wa      = 0;
    bit  wb      = 0;

    assign zero_w = '0;

    tff_counter_bank #(.WIDTH(W), .MOD(MOD), .RESET_VAL(0)) u_bank_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d),
        .q(q_a), .qb(qb_a), .tc(tc_a), .wrap(wrap_a)
    );

    tff_counter_bank #(.WIDTH(W), .MOD(MOD), .RESET_VAL(0)) u_bank_b (
        .clk(clk), .rst(rst), .en(tc_a), .mode(2'b01), .t(zero_w), .d(zero_w),
        .q(q_b), .qb(qb_b), .tc(tc_b), .wrap(wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Spec rules in plain integer arithmetic.
    function automatic int next_q(input int cur, input bit e, input bit [1:0] m,
                                  input int tt, input int dd);
        if (!e) return cur;
        case (m)
            2'b00:   return cur ^ tt;
            2'b01:   return (cur >= MOD - 1) ? 0 : cur + 1;
            2'b10:   return (cur == 0 || cur >= MOD) ? MOD - 1 : cur - 1;
            default: return dd;
        endcase
    endfunction

    function automatic bit next_w(input int cur, input bit e, input bit [1:0] m);
        return e && ((m == 2'b01 && cur >= MOD - 1) || (m == 2'b10 && cur == 0));
    endfunction

    function automatic bit tc_of(input int cur, input bit e, input bit [1:0] m);
        return next_w(cur, e, m);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma <= 0; wa <= 0; mb <= 0; wb <= 0;
        end else begin
            ma <= next_q(ma, en, mode, int'(t), int'(d));
            wa <= next_w(ma, en, mode);
            mb <= next_q(mb, tc_of(ma, en, mode), 2'b01, 0, 0);
            wb <= next_w(mb, tc_of(ma, en, mode), 2'b01);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model q_a", int'(q_a), ma);
            check("model qb_a", int'(qb_a), (~ma) & 15);
            check("model wrap_a", int'(wrap_a), int'(wa));
            check("model tc_a", int'(tc_a), int'(tc_of(ma, en, mode)));
            check("model q_b", int'(q_b), mb);
            check("model wrap_b", int'(wrap_b), int'(wb));
            check("model tc_b", int'(tc_b), int'(tc_of(mb, tc_of(ma, en, mode), 2'b01)));
        end
    end

    // Called #1 after a rising edge; returns #1 after the next one.
    task automatic step(input bit e, input bit [1:0] m, input int tt, input int dd);
        en = e; mode = m; t = W'(tt); d = W'(dd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int up_q[12];
        int dn_q[4];
        up_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        dn_q = '{1, 0, 9, 8};
        rst = 1'b0; en = 1'b0; mode = 2'b00; t = '0; d = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset q", int'(q_a), 0);
        check("reset qb", int'(qb_a), 15);
        check("reset wrap", int'(wrap_a), 0);
        chk_on = 1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 2'b01, 0, 0);
            check("en0 idle q", int'(q_a), 0);
        end

        for (int i = 0; i < 12; i++) begin
            step(1, 2'b01, 0, 0);
            check("up q", int'(q_a), up_q[i]);
            check("up wrap", int'(wrap_a), (i == 9) ? 1 : 0);
            check("up tc", int'(tc_a), (up_q[i] == 9) ? 1 : 0);
        end

        for (int i = 0; i < 4; i++) begin
            step(1, 2'b10, 0, 0);
            check("down q", int'(q_a), dn_q[i]);
            check("down wrap", int'(wrap_a), (i == 2) ? 1 : 0);
        end

        step(1, 2'b11, 0, 3);
        check("load 3", int'(q_a), 3);
        step(1, 2'b00, 5, 0);
        check("toggle 0101", int'(q_a), 6);
        check("toggle qb", int'(qb_a), 9);
        step(1, 2'b00, 15, 0);
        check("toggle 1111", int'(q_a), 9);
        check("toggle qb inv", int'(qb_a), 6);
        step(1, 2'b00, 0, 0);
        check("toggle hold", int'(q_a), 9);

        step(1, 2'b11, 0, 13);
        check("load 13", int'(q_a), 13);
        check("load tc", int'(tc_a), 0);
        step(1, 2'b01, 0, 0);
        check("up from 13 q", int'(q_a), 0);
        check("up from 13 wrap", int'(wrap_a), 1);
        step(1, 2'b11, 0, 13);
        step(1, 2'b10, 0, 0);
        check("down clamp q", int'(q_a), 9);
        check("down clamp wrap", int'(wrap_a), 0);
        step(1, 2'b01, 0, 0);
        check("wrap again", int'(wrap_a), 1);
        step(0, 2'b11, 0, 7);
        check("en0 hold q", int'(q_a), 0);
        check("en0 clears wrap", int'(wrap_a), 0);

        step(1, 2'b11, 0, 9);
        step(1, 2'b01, 0, 0);
        check("pre-reset wrap", int'(wrap_a), 1);
        #2 rst = 1'b0;
        #1;
        check("async reset q", int'(q_a), 0);
        check("async reset wrap", int'(wrap_a), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 35; i++) step(1, 2'b01, 0, 0);
        check("cascade A", int'(q_a), 5);
        check("cascade B", int'(q_b), 3);
        #2 rst = 1'b0;
        #1;
        check("cascade reset A", int'(q_a), 0);
        check("cascade reset B", int'(q_b), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(1, 2'b01, 0, 0);
        check("after release A", int'(q_a), 1);
        step(0, 2'b00, 0, 0);

        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
